// File: rtl/rf_write_scheduler_if.sv
// Write-back request bundle between the execute/memory stages, the init control and the
// register-file write port driven by rf_write_scheduler.
interface rf_write_scheduler_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [1:0]    req_valid;
  logic [AW-1:0] req_reg0;
  logic [DW-1:0] req_dat0;
  logic [AW-1:0] req_reg1;
  logic [DW-1:0] req_dat1;
  logic [1:0]    req_ready;
  logic          init_start;
  logic          init_busy;
  logic          init_done;
  logic [AW-1:0] regW;
  logic [DW-1:0] Wdat;
  logic          RegWrite;

  // Requesters, init control and register file together form the master side.
  modport master (
    output req_valid, req_reg0, req_dat0, req_reg1, req_dat1, init_start,
    input  req_ready, init_busy, init_done, regW, Wdat, RegWrite
  );

  modport slave (
    input  req_valid, req_reg0, req_dat0, req_reg1, req_dat1, init_start,
    output req_ready, init_busy, init_done, regW, Wdat, RegWrite
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Single owner of the register-file write port: round-robin arbiter between ALU (port 0)
// and MEM (port 1) write-backs, plus an init sequencer that rewrites r1..r(2**AW-1).
module rf_write_scheduler #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int INIT_INDEX = 1
) (
  input logic               clk,
  input logic               Rst,
  rf_write_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

  localparam logic [AW-1:0] IDX_LAST = '1;
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          rr_last;
  logic          init_last;
  logic          grant_vld;
  logic          grant_sel;
  logic [AW-1:0] grant_reg;
  logic [DW-1:0] grant_dat;
  logic [DW-1:0] init_dat;

  assign init_last = (idx == IDX_LAST);
  assign init_dat  = (INIT_INDEX != 0) ? {{(DW-AW){1'b0}}, idx} : '0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_nxt = state;
    idx_nxt   = idx;
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        // A start request pre-empts any pending write-back in the same cycle.
        if (bus.init_start) begin
          state_nxt = INIT;
          idx_nxt   = IDX_ONE;
        end else if (&bus.req_valid) begin
          grant_vld = 1'b1;
          grant_sel = ~rr_last;
        end else if (bus.req_valid[0]) begin
          grant_vld = 1'b1;
        end else if (bus.req_valid[1]) begin
          grant_vld = 1'b1;
          grant_sel = 1'b1;
        end
      end
      INIT: begin
        idx_nxt = idx + IDX_ONE;
        if (init_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_reg     = grant_sel ? bus.req_reg1 : bus.req_reg0;
  assign grant_dat     = grant_sel ? bus.req_dat1 : bus.req_dat0;
  assign bus.req_ready = grant_vld ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.init_busy = (state == INIT);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      idx          <= '0;
      rr_last      <= 1'b1;
      bus.regW     <= '0;
      bus.Wdat     <= '0;
      bus.RegWrite <= 1'b0;
      bus.init_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state         <= state_nxt;
      idx           <= idx_nxt;
      bus.RegWrite  <= 1'b0;
      bus.init_done <= 1'b0;
      if (state == INIT) begin
        bus.RegWrite  <= 1'b1;
        bus.regW      <= idx;
        bus.Wdat      <= init_dat;
        bus.init_done <= init_last;
      end else if (grant_vld) begin
        // r0 is hard-wired zero: the request is consumed but never written.
        rr_last      <= grant_sel;
        bus.regW     <= grant_reg;
        bus.Wdat     <= grant_dat;
        bus.RegWrite <= (grant_reg != '0);
      end
    end
  end

  a_no_grant_in_init: assert property (
    @(posedge clk) disable iff (Rst) bus.init_busy |-> (bus.req_ready == 2'b00));

  a_single_grant: assert property (
    @(posedge clk) disable iff (Rst) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: vector table, directed init/reset sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rf_write_scheduler;

  logic clk;
  logic Rst;

  rf_write_scheduler_if #(.DW(32), .AW(5)) u_if ();
  rf_write_scheduler_if #(.DW(32), .AW(5)) u_if0 ();

  rf_write_scheduler #(.DW(32), .AW(5), .INIT_INDEX(1)) u_dut (
    .clk (clk),
    .Rst (Rst),
    .bus (u_if.slave)
  );

  rf_write_scheduler #(.DW(32), .AW(5), .INIT_INDEX(0)) u_dut0 (
    .clk (clk),
    .Rst (Rst),
    .bus (u_if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  r0;
    logic [31:0] d0;
    logic [4:0]  r1;
    logic [31:0] d1;
    logic [1:0]  ready;
    logic        we;
    logic [4:0]  regw;
    logic [31:0] wdat;
  } vec_t;

  vec_t vec [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                       input logic [4:0] r1, input logic [31:0] d1, input logic st);
    u_if.req_valid  = v;
    u_if.req_reg0   = r0;
    u_if.req_dat0   = d0;
    u_if.req_reg1   = r1;
    u_if.req_dat1   = d1;
    u_if.init_start = st;
  endtask

  // Reference model state for the random phase.
  int          init_q[$];
  int          last_winner;
  logic [1:0]  rv;
  logic [4:0]  rr [2];
  logic [31:0] rd [2];
  logic        hold [2];
  logic        st;
  logic [1:0]  exp_ready;
  logic        exp_busy;
  logic        n_we;
  logic [4:0]  n_reg;
  logic [31:0] n_dat;
  logic        n_done;
  int          n_done_seen;

  initial begin
    Rst = 1'b1;
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    u_if0.req_valid  = 2'b00;
    u_if0.req_reg0   = '0;
    u_if0.req_dat0   = '0;
    u_if0.req_reg1   = '0;
    u_if0.req_dat1   = '0;
    u_if0.init_start = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("rst_regW",      64'(u_if.regW),      64'(0));
    check("rst_Wdat",      64'(u_if.Wdat),      64'(0));
    check("rst_RegWrite",  64'(u_if.RegWrite),  64'(0));
    check("rst_init_busy", 64'(u_if.init_busy), 64'(0));
    check("rst_init_done", 64'(u_if.init_done), 64'(0));
    Rst = 1'b0;

    // Round-robin from reset, single port, r0 drop, rr_last update on r0 transfer.
    vec[0] = '{2'b11, 5'd3, 32'hA000_0003, 5'd7, 32'hB000_0007, 2'b01, 1'b1, 5'd3, 32'hA000_0003};
    vec[1] = '{2'b11, 5'd3, 32'hA000_0003, 5'd7, 32'hB000_0007, 2'b10, 1'b1, 5'd7, 32'hB000_0007};
    vec[2] = '{2'b11, 5'd3, 32'hA000_0003, 5'd7, 32'hB000_0007, 2'b01, 1'b1, 5'd3, 32'hA000_0003};
    vec[3] = '{2'b11, 5'd3, 32'hA000_0003, 5'd7, 32'hB000_0007, 2'b10, 1'b1, 5'd7, 32'hB000_0007};
    vec[4] = '{2'b10, 5'd0, 32'h0,         5'd5, 32'hDEAD_BEEF, 2'b10, 1'b1, 5'd5, 32'hDEAD_BEEF};
    vec[5] = '{2'b01, 5'd0, 32'h0000_0055, 5'd0, 32'h0,         2'b01, 1'b0, 5'd0, 32'h0};
    vec[6] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 1'b0, 5'd0, 32'h0};
    vec[7] = '{2'b11, 5'd9, 32'h0900_0009, 5'd10, 32'h1000_000A, 2'b10, 1'b1, 5'd10, 32'h1000_000A};
    vec[8] = '{2'b11, 5'd9, 32'h0900_0009, 5'd10, 32'h1000_000A, 2'b01, 1'b1, 5'd9, 32'h0900_0009};

    for (int i = 0; i < 9; i++) begin
      drive(vec[i].valid, vec[i].r0, vec[i].d0, vec[i].r1, vec[i].d1, 1'b0);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(u_if.req_ready), 64'(vec[i].ready));
      tick();
      check($sformatf("vec%0d_RegWrite", i), 64'(u_if.RegWrite), 64'(vec[i].we));
      if (vec[i].we) begin
        check($sformatf("vec%0d_regW", i), 64'(u_if.regW), 64'(vec[i].regw));
        check($sformatf("vec%0d_Wdat", i), 64'(u_if.Wdat), 64'(vec[i].wdat));
      end
    end

    // Init sequence started while port 0 is waiting.
    drive(2'b01, 5'd4, 32'h0000_00AB, 5'd0, 32'h0, 1'b1);
    #1;
    check("init_start_ready", 64'(u_if.req_ready), 64'(0));
    tick();
    u_if.init_start = 1'b0;
    check("init_first_RegWrite", 64'(u_if.RegWrite), 64'(0));
    for (int k = 1; k <= 31; k++) begin
      #1;
      check($sformatf("init%0d_ready", k), 64'(u_if.req_ready), 64'(0));
      check($sformatf("init%0d_busy", k),  64'(u_if.init_busy), 64'(1));
      tick();
      check($sformatf("init%0d_RegWrite", k), 64'(u_if.RegWrite), 64'(1));
      check($sformatf("init%0d_regW", k),     64'(u_if.regW),     64'(k));
      check($sformatf("init%0d_Wdat", k),     64'(u_if.Wdat),     64'(k));
      check($sformatf("init%0d_done", k),     64'(u_if.init_done), 64'(k == 31));
    end
    #1;
    check("post_init_ready", 64'(u_if.req_ready), 64'(2'b01));
    check("post_init_busy",  64'(u_if.init_busy), 64'(0));
    tick();
    check("post_init_regW", 64'(u_if.regW), 64'(4));
    check("post_init_Wdat", 64'(u_if.Wdat), 64'(32'hAB));
    check("post_init_done", 64'(u_if.init_done), 64'(0));
    drive(2'b00, '0, '0, '0, '0, 1'b0);

    // Reset asserted mid-sequence at idx 9.
    u_if.init_start = 1'b1;
    tick();
    u_if.init_start = 1'b0;
    repeat (8) tick();
    check("midrst_pre_regW", 64'(u_if.regW), 64'(8));
    Rst = 1'b1;
    #1;
    check("midrst_regW",      64'(u_if.regW),      64'(0));
    check("midrst_Wdat",      64'(u_if.Wdat),      64'(0));
    check("midrst_RegWrite",  64'(u_if.RegWrite),  64'(0));
    check("midrst_init_busy", 64'(u_if.init_busy), 64'(0));
    check("midrst_init_done", 64'(u_if.init_done), 64'(0));
    tick();
    Rst = 1'b0;
    drive(2'b11, 5'd2, 32'h2222_2222, 5'd6, 32'h6666_6666, 1'b0);
    #1;
    check("midrst_after_busy",  64'(u_if.init_busy), 64'(0));
    check("midrst_after_ready", 64'(u_if.req_ready), 64'(2'b01));
    tick();
    check("midrst_after_regW", 64'(u_if.regW), 64'(2));
    drive(2'b00, '0, '0, '0, '0, 1'b0);
    tick();
    check("midrst_no_stray_write", 64'(u_if.RegWrite), 64'(0));

    // INIT_INDEX=0 instance, with a second start pulse inside the sequence.
    n_done_seen = 0;
    u_if0.init_start = 1'b1;
    tick();
    u_if0.init_start = 1'b0;
    u_if0.req_valid  = 2'b11;
    for (int k = 1; k <= 31; k++) begin
      u_if0.init_start = (k == 10);
      #1;
      check($sformatf("zinit%0d_ready", k), 64'(u_if0.req_ready), 64'(0));
      tick();
      if (u_if0.init_done) n_done_seen++;
      check($sformatf("zinit%0d_RegWrite", k), 64'(u_if0.RegWrite), 64'(1));
      check($sformatf("zinit%0d_regW", k),     64'(u_if0.regW),     64'(k));
      check($sformatf("zinit%0d_Wdat", k),     64'(u_if0.Wdat),     64'(0));
    end
    u_if0.init_start = 1'b0;
    u_if0.req_valid  = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("zpost%0d_busy", k), 64'(u_if0.init_busy), 64'(0));
      tick();
      if (u_if0.init_done) n_done_seen++;
      check($sformatf("zpost%0d_RegWrite", k), 64'(u_if0.RegWrite), 64'(0));
    end
    check("zinit_done_count", 64'(n_done_seen), 64'(1));

    // Randomized traffic against the reference model.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    last_winner = 1;
    init_q.delete();
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    rv = 2'b00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          rv[p] = ($urandom_range(0, 9) < 6);
          rr[p] = 5'($urandom_range(0, 31));
          rd[p] = $urandom;
        end
      end
      st = ($urandom_range(0, 39) == 0);
      drive(rv, rr[0], rd[0], rr[1], rd[1], st);

      exp_busy = (init_q.size() > 0);
      exp_ready = 2'b00;
      n_we = 1'b0;
      n_reg = '0;
      n_dat = '0;
      n_done = 1'b0;
      if (exp_busy) begin
        int k;
        k = init_q.pop_front();
        n_we   = 1'b1;
        n_reg  = 5'(k);
        n_dat  = 32'(k);
        n_done = (init_q.size() == 0);
      end else if (st) begin
        for (int k = 1; k <= 31; k++) init_q.push_back(k);
      end else if (rv != 2'b00) begin
        int g;
        if (rv == 2'b11) g = 1 - last_winner;
        else g = rv[0] ? 0 : 1;
        last_winner = g;
        exp_ready[g] = 1'b1;
        n_we  = (rr[g] != 5'd0);
        n_reg = rr[g];
        n_dat = rd[g];
      end

      #1;
      check("rnd_ready", 64'(u_if.req_ready), 64'(exp_ready));
      check("rnd_busy",  64'(u_if.init_busy), 64'(exp_busy));
      for (int p = 0; p < 2; p++) hold[p] = rv[p] && !exp_ready[p];
      tick();
      check("rnd_RegWrite", 64'(u_if.RegWrite), 64'(n_we));
      check("rnd_done",     64'(u_if.init_done), 64'(n_done));
      if (n_we) begin
        check("rnd_regW", 64'(u_if.regW), 64'(n_reg));
        check("rnd_Wdat", 64'(u_if.Wdat), 64'(n_dat));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
